dmem_mmio_uart: RTL and testbench

- Sits on the core's data-memory write channel, between the core and the data RAM.
- Decodes the PUTC and EXIT MMIO addresses and keeps those writes away from the RAM.
- Buffers PUTC bytes in a FIFO and serialises them as 8N1 on a UART TX pin. EXIT writes are latched as a sticky exit status.
- Lets the simulation console and exit path also run on FPGA builds.

---
 rtl/dmem_mmio_uart_if.sv | 21 ++
 rtl/dmem_mmio_uart.sv | 165 ++++++++++++++++
 tb/tb_dmem_mmio_uart.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_mmio_uart_if.sv
// Data-memory write channel between the core and dmem_mmio_uart.
// A write completes on a rising clk edge where wreq && wvalid; the core holds
// waddr/wdata/wstrb stable while wreq is high and wvalid is low.
interface dmem_mmio_uart_if;
    logic        wreq;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        mem_wready;

    modport master (
        output wreq, waddr, wdata, wstrb,
        input  wvalid, mem_wready
    );

    modport slave (
        input  wreq, waddr, wdata, wstrb,
        output wvalid, mem_wready
    );
endinterface

// File: rtl/dmem_mmio_uart.sv
// MMIO tap on the dmem write channel: PUTC bytes go to an 8N1 UART TX through a
// FIFO, EXIT writes latch a sticky exit code, everything else passes to the RAM.
module dmem_mmio_uart #(
    parameter logic [31:0] PUTC_ADDR  = 32'h9000001c,
    parameter logic [31:0] EXIT_ADDR  = 32'h9000002c,
    parameter int          FIFO_DEPTH = 16,
    parameter int          CLKDIV     = 16
) (
    input  logic                          clk,
    input  logic                          resetb,
    dmem_mmio_uart_if.slave               bus,
    output logic                          uart_tx,
    output logic                          exit_valid,
    output logic [31:0]                   exit_code,
    output logic                          tx_idle,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [1:0]                    dbg_tx_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKDIV);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_e;

    tx_state_e   state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic        exit_valid_q, exit_valid_d;
    logic [31:0] exit_code_q, exit_code_d;
    logic [7:0]  mem_q [FIFO_DEPTH];

    logic hit_putc, hit_exit, fifo_full, fifo_empty;
    logic accept, push, pop, timer_done;
    logic unused_strb;

    assign hit_putc   = (bus.waddr == PUTC_ADDR);
    assign hit_exit   = (bus.waddr == EXIT_ADDR);
    assign fifo_full  = (count_q == LW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // Full flag only: a pop in the same cycle does not open the door early.
    assign bus.wvalid     = !(hit_putc && fifo_full);
    assign bus.mem_wready = bus.wreq && !hit_putc && !hit_exit;
    assign accept     = bus.wreq && bus.wvalid;
    assign push       = accept && hit_putc && bus.wstrb[0];
    assign timer_done = (timer_q == CW'(CLKDIV - 1));
    assign unused_strb = ^bus.wstrb[3:1];

    assign uart_tx      = tx_q;
    assign exit_valid   = exit_valid_q;
    assign exit_code    = exit_code_q;
    assign fifo_level   = count_q;
    assign tx_idle      = (state_q == ST_IDLE) && fifo_empty;
    assign dbg_tx_state = state_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        exit_valid_d = exit_valid_q;
        exit_code_d  = exit_code_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + LW'(push) - LW'(pop);
        if (accept && hit_exit && !exit_valid_q) begin
            exit_valid_d = 1'b1;
            exit_code_d  = bus.wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    timer_d = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (timer_done) begin
                    timer_d   = '0;
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    timer_d = timer_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (timer_done) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + CW'(1);
                end
            end
            ST_STOP: begin
                // Chain straight into the next start bit when more bytes wait.
                if (timer_done) begin
                    timer_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            exit_valid_q <= 1'b0;
            exit_code_q  <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            exit_valid_q <= exit_valid_d;
            exit_code_q  <= exit_code_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.wdata[7:0];
    end
endmodule

// File: tb/tb_dmem_mmio_uart.sv
// Bench for dmem_mmio_uart: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized write traffic.
module tb_dmem_mmio_uart;
    localparam int          CLKDIV     = 4;
    localparam int          FIFO_DEPTH = 16;
    localparam int          LW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] PUTC_ADDR  = 32'h9000001c;
    localparam logic [31:0] EXIT_ADDR  = 32'h9000002c;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetb = 1'b0;
    always #5 clk = ~clk;

    logic          uart_tx, exit_valid, tx_idle;
    logic [31:0]   exit_code;
    logic [LW-1:0] fifo_level;
    logic [1:0]    dbg_tx_state;

    dmem_mmio_uart_if bus ();

    dmem_mmio_uart #(
        .PUTC_ADDR (PUTC_ADDR),
        .EXIT_ADDR (EXIT_ADDR),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CLKDIV    (CLKDIV)
    ) dut (
        .clk         (clk),
        .resetb      (resetb),
        .bus         (bus),
        .uart_tx     (uart_tx),
        .exit_valid  (exit_valid),
        .exit_code   (exit_code),
        .tx_idle     (tx_idle),
        .fifo_level  (fifo_level),
        .dbg_tx_state(dbg_tx_state)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Bytes waiting to be sent, plus the frame currently on the wire: the line
    // level is a pure function of the frame byte and the cycle within the frame.
    logic [7:0]  exp_q[$];
    bit          m_act = 1'b0;
    int          m_cyc = 0;
    logic [7:0]  m_cur = 8'h00;
    logic        m_exv = 1'b0;
    logic [31:0] m_exc = 32'h0;
    logic        m_acc;

    function automatic logic m_wvalid();
        return !(bus.waddr == PUTC_ADDR && exp_q.size() == FIFO_DEPTH);
    endfunction

    function automatic logic m_tx();
        int n;
        if (!m_act) return 1'b1;
        n = m_cyc / CLKDIV;
        if (n == 0) return 1'b0;
        if (n >= 9) return 1'b1;
        return m_cur[n-1];
    endfunction

    initial forever begin
        @(posedge clk or negedge resetb);
        if (!resetb) begin
            exp_q.delete();
            m_act = 1'b0;
            m_cyc = 0;
            m_exv = 1'b0;
            m_exc = 32'h0;
        end else begin
            m_acc = bus.wreq && m_wvalid();
            if (m_act) begin
                m_cyc++;
                if (m_cyc == 10 * CLKDIV) m_act = 1'b0;
            end
            if (!m_act && exp_q.size() > 0) begin
                m_cur = exp_q.pop_front();
                m_act = 1'b1;
                m_cyc = 0;
            end
            if (m_acc && bus.waddr == PUTC_ADDR && bus.wstrb[0]) exp_q.push_back(bus.wdata[7:0]);
            if (m_acc && bus.waddr == EXIT_ADDR && !m_exv) begin
                m_exv = 1'b1;
                m_exc = bus.wdata;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    initial forever begin
        @(negedge clk);
        chk("uart_tx",    32'(uart_tx),    32'(m_tx()));
        chk("tx_idle",    32'(tx_idle),    32'(!m_act && exp_q.size() == 0));
        chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
        chk("exit_valid", 32'(exit_valid), 32'(m_exv));
        chk("exit_code",  exit_code,       m_exc);
        chk("wvalid",     32'(bus.wvalid), 32'(m_wvalid()));
        chk("mem_wready", 32'(bus.mem_wready),
            32'(bus.wreq && bus.waddr != PUTC_ADDR && bus.waddr != EXIT_ADDR));
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge
    // with the request still asserted so writes can run back to back.
    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        bus.wreq  = 1'b1;
        bus.waddr = a;
        bus.wdata = d;
        bus.wstrb = s;
        @(negedge clk);
        while (!bus.wvalid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            chk("put_timeout", 32'(n), 32'(0));
            bus.wreq = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic release_bus();
        bus.wreq  = 1'b0;
        bus.waddr = 32'h0000_1000;
        bus.wstrb = 4'h0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!tx_idle && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_idle_timeout", 32'(n < limit), 32'(1));
    endtask

    logic [9:0]  lit_bits;
    int          r;
    logic [31:0] ra;
    logic [3:0]  rs;

    initial begin
        release_bus();
        bus.wdata = 32'h0;
        lit_bits  = 10'b1010101010;
        repeat (3) @(posedge clk);
        #1 resetb = 1'b1;

        chk("rst_uart_tx",    32'(uart_tx),    32'(1));
        chk("rst_tx_idle",    32'(tx_idle),    32'(1));
        chk("rst_fifo_level", 32'(fifo_level), 32'(0));
        chk("rst_exit_valid", 32'(exit_valid), 32'(0));
        chk("rst_exit_code",  exit_code,       32'h0);

        // Single 0x55 frame
        put(PUTC_ADDR, 32'h0000_0055, 4'b0001);
        release_bus();
        chk("t1_tx_at_accept", 32'(uart_tx), 32'(1));
        @(posedge clk);
        #1;
        for (int c = 0; c < 10 * CLKDIV; c++) begin
            if (c == 0) chk("t1_start_edge", 32'(uart_tx), 32'(0));
            if (c % CLKDIV == CLKDIV / 2) chk("t1_bit", 32'(uart_tx), 32'(lit_bits[c / CLKDIV]));
            chk("t1_mem_wready", 32'(bus.mem_wready), 32'(0));
            @(posedge clk);
            #1;
        end
        chk("t1_tx_idle_after", 32'(tx_idle), 32'(1));

        // EXIT latching is first-write-wins
        put(EXIT_ADDR, 32'h0000_002A, 4'hF);
        release_bus();
        chk("exit_valid_1", 32'(exit_valid), 32'(1));
        chk("exit_code_1",  exit_code,       32'h0000_002A);
        put(EXIT_ADDR, 32'h0000_FFFF, 4'hF);
        release_bus();
        chk("exit_code_2",  exit_code,       32'h0000_002A);

        // Plain RAM write
        bus.wreq  = 1'b1;
        bus.waddr = 32'h0002_0010;
        bus.wdata = 32'hDEAD_BEEF;
        bus.wstrb = 4'hF;
        #1;
        chk("ram_mem_wready", 32'(bus.mem_wready), 32'(1));
        chk("ram_wvalid",     32'(bus.wvalid),     32'(1));
        @(posedge clk);
        #1;
        release_bus();
        chk("ram_fifo_level", 32'(fifo_level), 32'(0));
        chk("ram_exit_code",  exit_code,       32'h0000_002A);

        // PUTC without byte-0 strobe is swallowed
        put(PUTC_ADDR, 32'h0000_0041, 4'b0010);
        release_bus();
        chk("nostrb_fifo_level", 32'(fifo_level), 32'(0));
        repeat (5) @(posedge clk);
        #1;
        chk("nostrb_uart_tx", 32'(uart_tx), 32'(1));
        chk("nostrb_tx_idle", 32'(tx_idle), 32'(1));

        // 17 back-to-back bytes fill the FIFO, an 18th must wait
        for (int i = 0; i < 17; i++) put(PUTC_ADDR, 32'h41 + 32'(i), 4'b0001);
        chk("b2b_level_full", 32'(fifo_level), 32'(16));
        bus.wdata = 32'h0000_0052;
        #1;
        chk("b2b_wvalid_full", 32'(bus.wvalid), 32'(0));
        put(PUTC_ADDR, 32'h0000_0052, 4'b0001);
        release_bus();
        chk("b2b_level_after", 32'(fifo_level), 32'(16));
        wait_idle(2000);

        // Reset during data bit 3 of the first of three queued bytes
        put(PUTC_ADDR, 32'h0000_0000, 4'b0001);
        put(PUTC_ADDR, 32'h0000_005A, 4'b0001);
        put(PUTC_ADDR, 32'h0000_0033, 4'b0001);
        release_bus();
        repeat (4 * CLKDIV + CLKDIV / 2 - 1) @(posedge clk);
        #1;
        chk("mid_tx_low", 32'(uart_tx), 32'(0));
        resetb = 1'b0;
        #1;
        chk("mid_rst_uart_tx", 32'(uart_tx),    32'(1));
        chk("mid_rst_level",   32'(fifo_level), 32'(0));
        chk("mid_rst_tx_idle", 32'(tx_idle),    32'(1));
        repeat (2) @(posedge clk);
        #1 resetb = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("post_rst_uart_tx", 32'(uart_tx),    32'(1));
        chk("post_rst_tx_idle", 32'(tx_idle),    32'(1));
        chk("post_rst_exit",    32'(exit_valid), 32'(0));

        // Randomized mixed traffic
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                ra = PUTC_ADDR;
                rs = 4'($urandom_range(0, 15)) | (($urandom_range(0, 3) != 0) ? 4'b0001 : 4'b0000);
            end else if (r == 5) begin
                ra = EXIT_ADDR;
                rs = 4'hF;
            end else begin
                ra = $urandom & 32'hFFFF_FFFC;
                if (ra == PUTC_ADDR || ra == EXIT_ADDR) ra = ra ^ 32'h0000_1000;
                rs = 4'($urandom_range(0, 15));
            end
            put(ra, $urandom, rs);
            if ($urandom_range(0, 2) == 0) begin
                release_bus();
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1;
            end
        end
        release_bus();
        wait_idle(10000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
